mtimer: RTL and testbench

Memory-mapped machine timer for the single-hart RV32I core. It holds a 64-bit free-running `mtime` counter and a 64-bit `mtimecmp` compare register, both reachable over a simple 32-bit register port. It drives the level-sensitive machine timer interrupt request `o_tip` straight into the CSR block's `i_Int_tip` input, which is the source of `mip.MTIP`.

---
 rtl/mtimer.sv | 138 +++++++++++++
 tb/tb_mtimer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mtimer.sv
// mtimer: memory-mapped machine timer for a single-hart RV32I core.
// Holds a 64-bit free-running mtime, a 64-bit mtimecmp and a 32-bit
// snapshot of mtime[63:32] taken on every MTIME_LO read. Drives the
// registered level interrupt o_tip = (mtime >= mtimecmp).
// Optional macro ARVI_MTIMER_PRESCALE_EN adds a 16-bit PRESCALE register
// and tick divider; without it mtime advances every cycle.
module mtimer #(
    parameter int          HART_ID = 0,
    parameter logic [63:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [4:0]  i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_ack,
    output logic        o_tip
);

    // Word offsets (byte address bits [4:2])
    localparam logic [2:0] W_MTIME_LO    = 3'd0;
    localparam logic [2:0] W_MTIME_HI    = 3'd1;
    localparam logic [2:0] W_MTIMECMP_LO = 3'd2;
    localparam logic [2:0] W_MTIMECMP_HI = 3'd3;
    localparam logic [2:0] W_PRESCALE    = 3'd4;

    logic [63:0] mtime_reg;
    logic [63:0] mtimecmp_reg;
    logic [31:0] shadow_reg;
    logic        tip_reg;
    logic        ack_reg;
    logic [31:0] rdata_reg;
    logic [31:0] rdata_next;
    logic [15:0] prescale_rd;
    logic        tick;

    logic [2:0] word;
    logic       wr_en;
    logic       rd_en;
    logic       mtime_wr;

    assign word     = i_addr[4:2];
    assign wr_en    = i_req & i_we;
    assign rd_en    = i_req & ~i_we;
    assign mtime_wr = wr_en & ((word == W_MTIME_LO) | (word == W_MTIME_HI));

    // HART_ID is reserved for multi-hart decode; byte-lane bits are ignored.
    logic unused_bits;
    assign unused_bits = ^{i_addr[1:0], 32'(HART_ID)};

`ifdef ARVI_MTIMER_PRESCALE_EN
    logic [15:0] prescale_reg;
    logic [15:0] pcnt_reg;

    assign tick        = (pcnt_reg == prescale_reg);
    assign prescale_rd = prescale_reg;

    // Prescale divider: tick when counter hits PRESCALE; any PRESCALE or mtime write restarts it
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            prescale_reg <= 16'd0;
            pcnt_reg     <= 16'd0;
        end else begin
            if (wr_en && (word == W_PRESCALE))
                prescale_reg <= i_wdata[15:0];
            if (mtime_wr || (wr_en && (word == W_PRESCALE)) || tick)
                pcnt_reg <= 16'd0;
            else
                pcnt_reg <= pcnt_reg + 16'd1;
        end
    end
`else
    assign tick        = 1'b1;
    assign prescale_rd = 16'd0;
`endif

    // mtime: a software write to either half wins over the tick (no increment, no carry)
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            mtime_reg <= 64'd0;
        end else if (wr_en && (word == W_MTIME_LO)) begin
            mtime_reg[31:0] <= i_wdata;
        end else if (wr_en && (word == W_MTIME_HI)) begin
            mtime_reg[63:32] <= i_wdata;
        end else if (tick) begin
            mtime_reg <= mtime_reg + 64'd1;
        end
    end

    // mtimecmp: half-word replacement on write
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            mtimecmp_reg <= CMP_RST;
        end else if (wr_en && (word == W_MTIMECMP_LO)) begin
            mtimecmp_reg[31:0] <= i_wdata;
        end else if (wr_en && (word == W_MTIMECMP_HI)) begin
            mtimecmp_reg[63:32] <= i_wdata;
        end
    end

    // Read mux from pre-edge register values; writes and idle cycles return 0
    always_comb begin
        rdata_next = 32'd0;
        if (rd_en) begin
            case (word)
                W_MTIME_LO:    rdata_next = mtime_reg[31:0];
                W_MTIME_HI:    rdata_next = shadow_reg;
                W_MTIMECMP_LO: rdata_next = mtimecmp_reg[31:0];
                W_MTIMECMP_HI: rdata_next = mtimecmp_reg[63:32];
                W_PRESCALE:    rdata_next = {16'd0, prescale_rd};
                default:       rdata_next = 32'd0;
            endcase
        end
    end

    // Response, snapshot and interrupt registers
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            ack_reg    <= 1'b0;
            rdata_reg  <= 32'd0;
            shadow_reg <= 32'd0;
            tip_reg    <= 1'b0;
        end else begin
            ack_reg   <= i_req;
            rdata_reg <= rdata_next;
            if (rd_en && (word == W_MTIME_LO))
                shadow_reg <= mtime_reg[63:32];
            tip_reg   <= (mtime_reg >= mtimecmp_reg);
        end
    end

    assign o_ack   = ack_reg;
    assign o_rdata = rdata_reg;
    assign o_tip   = tip_reg;

endmodule

// File: tb/tb_mtimer.sv
// tb_mtimer: directed and randomized checks of mtimer against a
// cycle-level behavioural model kept in this bench.
module tb_mtimer;

    localparam logic [4:0] A_LO    = 5'h00;
    localparam logic [4:0] A_HI    = 5'h04;
    localparam logic [4:0] A_CLO   = 5'h08;
    localparam logic [4:0] A_CHI   = 5'h0C;
    localparam logic [4:0] A_PRE   = 5'h10;
    localparam logic [63:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [4:0]  addr = 5'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        ack;
    logic        tip;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    logic [63:0] m_time;
    logic [63:0] m_cmp;
    logic [31:0] m_shadow;
    logic [15:0] m_pre;
    logic [15:0] m_pcnt;
    logic        e_ack;
    logic        e_tip;
    logic [31:0] e_rdata;

    mtimer dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_req   (req),
        .i_we    (we),
        .i_addr  (addr),
        .i_wdata (wdata),
        .o_rdata (rdata),
        .o_ack   (ack),
        .o_tip   (tip)
    );

    always #5 clk = ~clk;

    // Model of one clock edge: responses from the old state, then state update
    task automatic model_edge(input logic rn, input logic rq, input logic w,
                              input logic [4:0] a, input logic [31:0] d);
        logic [2:0] wd;
        logic       tk;
        if (!rn) begin
            m_time = 64'd0; m_cmp = CMP_RST; m_shadow = 32'd0;
            m_pre = 16'd0; m_pcnt = 16'd0;
            e_ack = 1'b0; e_tip = 1'b0; e_rdata = 32'd0;
            return;
        end
        wd      = a[4:2];
        e_ack   = rq;
        e_rdata = 32'd0;
        e_tip   = (m_time >= m_cmp);
        if (rq && !w) begin
            if (wd == 3'd0) begin e_rdata = m_time[31:0]; m_shadow = m_time[63:32]; end
            else if (wd == 3'd1) e_rdata = m_shadow;
            else if (wd == 3'd2) e_rdata = m_cmp[31:0];
            else if (wd == 3'd3) e_rdata = m_cmp[63:32];
`ifdef ARVI_MTIMER_PRESCALE_EN
            else if (wd == 3'd4) e_rdata = {16'd0, m_pre};
`endif
        end
`ifdef ARVI_MTIMER_PRESCALE_EN
        tk = (m_pcnt == m_pre);
        if ((rq && w && wd <= 3'd1) || (rq && w && wd == 3'd4) || tk) m_pcnt = 16'd0;
        else m_pcnt = m_pcnt + 16'd1;
        if (rq && w && wd == 3'd4) m_pre = d[15:0];
`else
        tk = 1'b1;
`endif
        if (rq && w && wd == 3'd0)      m_time = {m_time[63:32], d};
        else if (rq && w && wd == 3'd1) m_time = {d, m_time[31:0]};
        else if (tk)                    m_time = m_time + 64'd1;
        if (rq && w && wd == 3'd2) m_cmp = {m_cmp[63:32], d};
        if (rq && w && wd == 3'd3) m_cmp = {d, m_cmp[31:0]};
    endtask

    // One clock cycle: drive inputs, advance to the edge, update model, settle
    task automatic cycle(input logic r, input logic w, input logic [4:0] a, input logic [31:0] d);
        req = r; we = w; addr = a; wdata = d;
        @(posedge clk);
        model_edge(rst, r, w, a, d);
        #1;
        req = 1'b0; we = 1'b0; addr = 5'd0; wdata = 32'd0;
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        cycle(1'b1, 1'b1, a, d);
    endtask

    task automatic rd(input logic [4:0] a);
        cycle(1'b1, 1'b0, a, 32'd0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) idle();
        n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack got %0b want 0", ack); end
        n_tests++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", rdata); end
        n_tests++; if (tip !== 1'b0) begin n_fail++; $display("FAIL reset_tip got %0b want 0", tip); end
        rst = 1'b1;
        repeat (10) idle();
        n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL idle_ack got %0b want 0", ack); end
        n_tests++; if (tip !== 1'b0) begin n_fail++; $display("FAIL idle_tip got %0b want 0", tip); end
        rd(A_LO);
        n_tests++; if (ack !== 1'b1) begin n_fail++; $display("FAIL rd_ack got %0b want 1", ack); end
        n_tests++; if (rdata !== 32'd10) begin n_fail++; $display("FAIL mtime_after_10 got %0d want 10", rdata); end
        idle();
        n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL ack_one_cycle got %0b want 0", ack); end
        n_tests++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL rdata_noack got %h want 0", rdata); end
        $display("[TB] test_reset done");
    endtask

    task automatic test_carry();
        wr(A_LO, 32'hFFFF_FFFE);
        n_tests++; if (ack !== 1'b1 || rdata !== 32'd0) begin n_fail++; $display("FAIL wr_ack got ack=%0b rdata=%h want 1/0", ack, rdata); end
        wr(A_HI, 32'd0);
        repeat (3) idle();
        rd(A_LO);
        n_tests++; if (rdata !== 32'd1) begin n_fail++; $display("FAIL carry_lo got %h want 1", rdata); end
        rd(A_HI);
        n_tests++; if (rdata !== 32'd1) begin n_fail++; $display("FAIL carry_hi got %h want 1", rdata); end
        $display("[TB] test_carry done");
    endtask

    task automatic test_tip();
        logic exp;
        wr(A_CHI, 32'd0);
        wr(A_CLO, 32'd50);
        wr(A_HI, 32'd0);
        wr(A_LO, 32'd0);
        for (int k = 1; k <= 60; k++) begin
            idle();
            exp = (k >= 51);
            n_tests++; if (tip !== exp) begin n_fail++; $display("FAIL tip_rise k=%0d got %0b want %0b", k, tip, exp); end
        end
        wr(A_CLO, 32'hFFFF_FFFF);
        n_tests++; if (tip !== 1'b1) begin n_fail++; $display("FAIL tip_hold got %0b want 1", tip); end
        idle();
        n_tests++; if (tip !== 1'b0) begin n_fail++; $display("FAIL tip_fall got %0b want 0", tip); end
        $display("[TB] test_tip done");
    endtask

    task automatic test_write_vs_carry();
        wr(A_HI, 32'd5);
        wr(A_LO, 32'hFFFF_FFFF);
        wr(A_LO, 32'h1234_5678);
        rd(A_LO);
        n_tests++; if (rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL wr_vs_tick_lo got %h want 12345678", rdata); end
        rd(A_HI);
        n_tests++; if (rdata !== 32'd5) begin n_fail++; $display("FAIL wr_vs_tick_hi got %h want 5", rdata); end
        $display("[TB] test_write_vs_carry done");
    endtask

    task automatic test_snapshot();
        wr(A_HI, 32'd1);
        wr(A_LO, 32'hFFFF_FFFF);
        rd(A_LO);
        n_tests++; if (rdata !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL snap_lo got %h want ffffffff", rdata); end
        repeat (5) idle();
        rd(A_HI);
        n_tests++; if (rdata !== 32'd1) begin n_fail++; $display("FAIL snap_hi got %h want 1", rdata); end
        rd(A_CHI);
        n_tests++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL cmp_hi got %h want 0", rdata); end
        rd(5'h1C);
        n_tests++; if (ack !== 1'b1 || rdata !== 32'd0) begin n_fail++; $display("FAIL unmapped got ack=%0b rdata=%h want 1/0", ack, rdata); end
        $display("[TB] test_snapshot done");
    endtask

    task automatic test_prescale();
        wr(A_PRE, 32'hABCD_0003);
        rd(A_PRE);
`ifdef ARVI_MTIMER_PRESCALE_EN
        n_tests++; if (rdata !== 32'd3) begin n_fail++; $display("FAIL prescale_rd got %h want 3", rdata); end
`else
        n_tests++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL prescale_rd got %h want 0", rdata); end
`endif
        wr(A_HI, 32'd0);
        wr(A_LO, 32'd0);
        repeat (20) idle();
        rd(A_LO);
`ifdef ARVI_MTIMER_PRESCALE_EN
        n_tests++; if (rdata !== 32'd5) begin n_fail++; $display("FAIL prescale_rate got %0d want 5", rdata); end
        wr(A_PRE, 32'd0);
`else
        n_tests++; if (rdata !== 32'd20) begin n_fail++; $display("FAIL prescale_rate got %0d want 20", rdata); end
`endif
        $display("[TB] test_prescale done");
    endtask

    task automatic test_back_to_back();
        logic       r;
        logic       w;
        logic [4:0] a;
        logic [31:0] d;
        for (int i = 0; i < 300; i++) begin
            r = ($urandom % 4) != 0;
            w = r && (($urandom % 4) == 0);
            a = 5'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
            d = $urandom;
            if (a[4:2] == 3'd4) d = d & 32'h7;
            if (a[4:2] == 3'd1 || a[4:2] == 3'd3) d = d & 32'h1;
            cycle(r, w, a, d);
            n_tests++; if (ack !== e_ack) begin n_fail++; $display("FAIL b2b_ack i=%0d got %0b want %0b", i, ack, e_ack); end
            n_tests++; if (rdata !== e_rdata) begin n_fail++; $display("FAIL b2b_rdata i=%0d got %h want %h", i, rdata, e_rdata); end
            n_tests++; if (tip !== e_tip) begin n_fail++; $display("FAIL b2b_tip i=%0d got %0b want %0b", i, tip, e_tip); end
            if (r) $display("[TB] b2b %0d %s addr=%h data=%h rdata=%h", i, w ? "wr" : "rd", a, d, rdata);
        end
        $display("[TB] test_back_to_back done");
    endtask

    task automatic test_reset_mid();
        rst = 1'b0;
        rd(A_LO);
        n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ack got %0b want 0", ack); end
        n_tests++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL rst_mid_rdata got %h want 0", rdata); end
        rst = 1'b1;
        idle();
        idle();
        rd(A_LO);
        n_tests++; if (rdata !== 32'd2) begin n_fail++; $display("FAIL rst_mid_mtime got %0d want 2", rdata); end
        rd(A_CHI);
        n_tests++; if (rdata !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rst_mid_cmp got %h want ffffffff", rdata); end
        n_tests++; if (tip !== 1'b0) begin n_fail++; $display("FAIL rst_mid_tip got %0b want 0", tip); end
        $display("[TB] test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_carry();
        test_tip();
        test_write_vs_carry();
        test_snapshot();
        test_prescale();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
